// File: rtl/lcd_timing_engine_if.sv
// lcd_timing_engine_if
//   Pixel-request bus between the LCD timing engine and its pixel source
//   (renderer, frame buffer, ...).
//   master (engine): drives pix_req, pix_x, pix_y, frame_start, line_start;
//                    receives pix_data_in.
//   slave  (source): the mirror image.
interface lcd_timing_engine_if #(
    parameter int HW    = 10,
    parameter int VW    = 9,
    parameter int RGB_W = 16
);
    logic             pix_req;
    logic [HW-1:0]    pix_x;
    logic [VW-1:0]    pix_y;
    logic             frame_start;
    logic             line_start;
    logic [RGB_W-1:0] pix_data_in;

    modport master (
        output pix_req, pix_x, pix_y, frame_start, line_start,
        input  pix_data_in
    );

    modport slave (
        input  pix_req, pix_x, pix_y, frame_start, line_start,
        output pix_data_in
    );
endinterface

// File: rtl/lcd_timing_engine.sv
// lcd_timing_engine
//   DE-mode RGB parallel LCD timing engine. Divides clk into pixel slots,
//   requests each active pixel from a pixel source one slot ahead of the
//   panel, and presents the returned colour on rgb aligned with de.
//
//   Ports:
//     clk, rst_n  system clock, asynchronous active-low reset
//     enable      run timing; low clears and idles the panel
//     pix_if      pixel-request bus (master side): pix_req, pix_x, pix_y,
//                 frame_start, line_start out; pix_data_in in
//     pclk        panel pixel clock (falls on every slot step)
//     de          panel data enable
//     rgb         panel colour bus
//     disp_on     panel display enable
//
//   Build option LCD_SYNC_OUT_EN: adds H_SYNC_W / V_SYNC_W parameters and
//   active-low hsync_n / vsync_n outputs aligned with de.
//
//   State  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | enable low or just after reset; divider held at 0
//   RUN    | timing running; divider cycles, slots step once per period
module lcd_timing_engine #(
    parameter int H_ACTIVE = 480,
    parameter int H_BLANK  = 256,
    parameter int V_ACTIVE = 272,
    parameter int V_BLANK  = 45,
    parameter int CLK_DIV  = 6,
    parameter int HW       = 10,
    parameter int VW       = 9,
    parameter int RGB_W    = 16
`ifdef LCD_SYNC_OUT_EN
    ,
    parameter int H_SYNC_W = 4,
    parameter int V_SYNC_W = 2
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    lcd_timing_engine_if.master       pix_if,
    output logic                      pclk,
    output logic                      de,
    output logic [RGB_W-1:0]          rgb,
    output logic                      disp_on
`ifdef LCD_SYNC_OUT_EN
    ,
    output logic                      hsync_n,
    output logic                      vsync_n
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HALF    = CLK_DIV / 2;
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_STEP = DW'(HALF - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(HALF);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] div_cnt, div_nxt;
    logic [HW-1:0] h_cnt, x_q;
    logic [VW-1:0] v_cnt, y_q;
    logic          run, step, slot_active;
    logic          act_q;
    logic          req_q, fs_q, ls_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state
    always_comb begin
        state_nxt = ST_IDLE;
        if (enable) begin
            state_nxt = ST_RUN;
        end
    end

    // state outputs: the divider only advances once RUN is entered, so the
    // first enabled clock still sees div_cnt = 0 and pclk gets a full high phase.
    always_comb begin
        run  = (state == ST_RUN);
        step = run && (div_cnt == DIV_STEP);
    end

    always_comb begin
        div_nxt = '0;
        if (run) begin
            div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
        end
    end

    assign slot_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
            disp_on <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            act_q   <= 1'b0;
            de      <= 1'b0;
            rgb     <= '0;
        end else if (!enable) begin
            div_cnt <= '0;
            pclk    <= 1'b0;
            disp_on <= 1'b0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            act_q   <= 1'b0;
            de      <= 1'b0;
            rgb     <= '0;
        end else begin
            div_cnt <= div_nxt;
            // registered so the panel clock never glitches on counter decode
            pclk    <= (div_nxt < DIV_HALF);
            disp_on <= 1'b1;
            req_q   <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            if (step) begin
                x_q   <= h_cnt;
                y_q   <= v_cnt;
                req_q <= slot_active;
                fs_q  <= slot_active && (h_cnt == '0) && (v_cnt == '0);
                ls_q  <= slot_active && (h_cnt == '0);
                // display runs one slot behind the request
                act_q <= slot_active;
                de    <= act_q;
                rgb   <= act_q ? pix_if.pix_data_in : '0;
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

`ifdef LCD_SYNC_OUT_EN
    // x_q/y_q still hold the previous request slot at the step edge, which
    // is exactly the slot being displayed next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (!enable) begin
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (step) begin
            hsync_n <= !((int'(x_q) >= H_ACTIVE) && (int'(x_q) < H_ACTIVE + H_SYNC_W));
            vsync_n <= !((int'(y_q) >= V_ACTIVE) && (int'(y_q) < V_ACTIVE + V_SYNC_W));
        end
    end
`endif

    assign pix_if.pix_req     = req_q;
    assign pix_if.pix_x       = x_q;
    assign pix_if.pix_y       = y_q;
    assign pix_if.frame_start = fs_q;
    assign pix_if.line_start  = ls_q;

endmodule
